// File: rtl/des_pkg.sv
// Shared definitions for the DES key schedule.
//   PC1         : permuted choice 1, 56 entries of DES bit numbers (1 = key MSB)
//   PC2         : permuted choice 2, 48 entries of C||D bit numbers (1 = C MSB)
//   SHIFT_SCHED : bit (i-1) set when round i rotates by one place, otherwise by two
//   rk_t        : one 48-bit round key
//   ks_state_t  : key schedule controller state
package des_pkg;

  localparam int ROUNDS = 16;
  localparam int RK_W   = 48;
  localparam int KEY_W  = 64;
  localparam int CD_W   = 56;
  localparam int HALF_W = 28;

  typedef logic [RK_W-1:0] rk_t;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    DONE
  } ks_state_t;

  localparam int PC1 [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [RK_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Rounds 1, 2, 9 and 16 rotate by one place.
  localparam logic [ROUNDS-1:0] SHIFT_SCHED = 16'h8103;

  // Left rotate of a 28-bit half; the MSB holds the lowest DES bit number,
  // so a left rotate moves DES bit 2 into position 1.
  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] v,
                                             input logic              single);
    return single ? {v[HALF_W-2:0], v[HALF_W-1]}
                  : {v[HALF_W-3:0], v[HALF_W-1:HALF_W-2]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Permuted choice 2: selects 48 of the 56 rotated C||D bits as one round key.
//   cd_i : {C, D}, bit 55 = C||D bit 1
//   rk_o : round key, bit 47 = round key bit 1
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd_i,
  output logic [47:0] rk_o
);

  for (genvar j = 0; j < RK_W; j++) begin : g_pc2
    assign rk_o[RK_W-1-j] = cd_i[CD_W-PC2[j]];
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one round key per cycle, full set held stable.
//   clk, rst    : clock, asynchronous active-high reset
//   key_valid   : key_in/decrypt valid, accepted while key_ready is high
//   key_in      : 64-bit DES key, bit 63 = DES bit 1, parity bits ignored
//   decrypt     : 0 = slot r1 holds K1, 1 = slot r1 holds K16
//   key_ready   : a new key can be accepted (IDLE or DONE)
//   keys_ready  : round_keys complete, held until the next accept
//   round_keys  : {r1, ..., r16}, r1 in [767:720]
module des_key_schedule
  import des_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [63:0]  key_in,
  input  logic         decrypt,
  output logic         key_ready,
  output logic         keys_ready,
  output logic [767:0] round_keys
);

  ks_state_t         state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [HALF_W-1:0] c_q, c_d, d_q, d_d;
  logic [HALF_W-1:0] c_rot, d_rot;
  logic              dec_q, dec_d;
  logic              keys_ready_q, keys_ready_d;
  logic [CD_W-1:0]   cd_pc1;
  rk_t               rk_new;
  rk_t               rk_q [ROUNDS];
  logic              accept;
  logic              rk_we;
  logic [3:0]        rk_idx;
  logic              unused_parity;

  // PC-1 drops the eight parity bits (DES bits 8, 16, ..., 64).
  for (genvar j = 0; j < CD_W; j++) begin : g_pc1
    assign cd_pc1[CD_W-1-j] = key_in[KEY_W-PC1[j]];
  end
  assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8],  key_in[0]};

  // Rotate and PC-2 are both combinational, so the key for round cnt_q+1
  // is ready to be stored at the end of the current cycle.
  assign c_rot = rotl(c_q, SHIFT_SCHED[cnt_q]);
  assign d_rot = rotl(d_q, SHIFT_SCHED[cnt_q]);

  des_pc2 u_pc2 (
    .cd_i ({c_rot, d_rot}),
    .rk_o (rk_new)
  );

  assign key_ready  = (state_q != GEN);
  assign accept     = key_valid & key_ready;
  assign keys_ready = keys_ready_q;
  assign rk_idx     = dec_q ? (4'(ROUNDS-1) - cnt_q) : cnt_q;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    c_d          = c_q;
    d_d          = d_q;
    dec_d        = dec_q;
    keys_ready_d = keys_ready_q;
    rk_we        = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d      = GEN;
          cnt_d        = '0;
          c_d          = cd_pc1[CD_W-1:HALF_W];
          d_d          = cd_pc1[HALF_W-1:0];
          dec_d        = decrypt;
          keys_ready_d = 1'b0;
        end
      end
      GEN: begin
        rk_we = 1'b1;
        c_d   = c_rot;
        d_d   = d_rot;
        cnt_d = cnt_q + 4'd1;
        // Sixteen rotations total 28 places, so C/D need no correction here.
        if (cnt_q == 4'(ROUNDS-1)) begin
          state_d      = DONE;
          keys_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      c_q          <= '0;
      d_q          <= '0;
      dec_q        <= 1'b0;
      keys_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      c_q          <= c_d;
      d_q          <= d_d;
      dec_q        <= dec_d;
      keys_ready_q <= keys_ready_d;
    end
  end

  // NOTE: the round-key store is reset, unlike a typical RAM, because a reset
  // mid-generation must not leave partial keys visible to the datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < ROUNDS; s++) rk_q[s] <= '0;
    end else if (rk_we) begin
      rk_q[rk_idx] <= rk_new;
    end
  end

  for (genvar s = 0; s < ROUNDS; s++) begin : g_out
    assign round_keys[RK_W*(ROUNDS-s)-1 -: RK_W] = rk_q[s];
  end

endmodule
